// File: rtl/network_ejector_vn_buffered_pkg.sv
// Shared definitions for the multi-VN ejection port.
// Flit type encodings, arbiter states and arbitration helpers.
package network_ejector_vn_buffered_pkg;

  localparam int FLIT_TYPE_W = 2;

  localparam logic [1:0] FLIT_HEADER      = 2'b00;
  localparam logic [1:0] FLIT_PAYLOAD     = 2'b01;
  localparam logic [1:0] FLIT_TAIL        = 2'b10;
  localparam logic [1:0] FLIT_HEADER_TAIL = 2'b11;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic logic is_pkt_end(
    input logic [1:0] ty
  );
    return (ty == FLIT_TAIL) ||
           (ty == FLIT_HEADER_TAIL);
  endfunction

  // First requester at or after start,
  // wrapping at n; start if none.
  function automatic int rr_pick(
    input logic [31:0] req,
    input int          start,
    input int          n
  );
    int k;
    rr_pick = start;
    for (int i = n - 1; i >= 0; i--) begin
      k = start + i;
      if (k >= n) k = k - n;
      if (req[k]) rr_pick = k;
    end
  endfunction

endpackage

// File: rtl/network_ejector_vn_buffered_if.sv
// Push/pop handshake between the ejector
// core (master) and one per-VN flit FIFO (slave).
interface network_ejector_vn_buffered_if #(
  parameter int W    = 69,
  parameter int CntW = 3
);
  logic            push;
  logic            pop;
  logic [W-1:0]    wdata;
  logic [W-1:0]    rdata;
  logic            full;
  logic            empty;
  logic [CntW-1:0] count;

  modport master (
    output push, pop, wdata,
    input  rdata, full, empty, count
  );

  modport slave (
    input  push, pop, wdata,
    output rdata, full, empty, count
  );
endinterface

// File: rtl/network_ejector_vn_buffered_fifo.sv
// Per-VN synchronous flit FIFO with registered
// occupancy; the master never pops empty or overfills.
module network_ejector_vn_buffered_fifo #(
  parameter int Width = 69,
  parameter int Depth = 4
) (
  input logic clk_i,
  input logic rst_ni,
  network_ejector_vn_buffered_if.slave fifo
);
  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;

  // Storage array, written on push.
  always_ff @(posedge clk_i) begin
    if (fifo.push) r_mem[r_wptr] <= fifo.wdata;
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (fifo.push) r_wptr <= r_wptr + 1'b1;
      if (fifo.pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count
               + CntW'(fifo.push)
               - CntW'(fifo.pop);
    end
  end

  assign fifo.rdata = r_mem[r_rptr];
  assign fifo.count = r_count;
  assign fifo.empty = (r_count == '0);
  assign fifo.full  = (r_count == CntW'(Depth));

endmodule

// File: rtl/network_ejector_vn_buffered.sv
// Multi-VN ejection port: per-VN FIFOs and avail lines,
// packet-atomic round-robin drain onto one stream.
module network_ejector_vn_buffered
  import network_ejector_vn_buffered_pkg::*;
#(
  parameter int NetworkIfFlitWidth               = 64,
  parameter int NetworkIfFlitTypeWidth           = 2,
  parameter int NetworkIfBroadcastWidth          = 1,
  parameter int NetworkIfVirtualNetworkIdWidth   = 2,
  parameter int NetworkIfNumberOfVirtualNetworks = 3,
  parameter int FifoDepth                        = 4,
  localparam int NetworkIfDataWidth =
    NetworkIfFlitWidth + NetworkIfFlitTypeWidth +
    NetworkIfBroadcastWidth +
    NetworkIfVirtualNetworkIdWidth
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic network_valid_i,
  output logic [NetworkIfNumberOfVirtualNetworks-1:0]
               network_ready_o,
  input  logic [NetworkIfFlitWidth-1:0]
               network_flit_i,
  input  logic [NetworkIfFlitTypeWidth-1:0]
               network_flit_type_i,
  input  logic [NetworkIfBroadcastWidth-1:0]
               network_broadcast_i,
  input  logic [NetworkIfVirtualNetworkIdWidth-1:0]
               network_virtual_network_id_i,
  output logic valid_o,
  input  logic ready_i,
  output logic [NetworkIfDataWidth-1:0] data_o,
  output logic overflow_o
);
  localparam int NumVn   = NetworkIfNumberOfVirtualNetworks;
  localparam int VnW     = NetworkIfVirtualNetworkIdWidth;
  localparam int DataW   = NetworkIfDataWidth;
  localparam int CntW    = $clog2(FifoDepth) + 1;
  localparam int TypeLsb = NetworkIfFlitWidth;
  localparam logic [CntW-1:0] AvailMax =
    CntW'(FifoDepth - 2);

  logic [DataW-1:0] w_wdata;
  logic             w_vn_ok;
  logic [NumVn-1:0] w_push_req;
  logic [NumVn-1:0] w_push;
  logic [NumVn-1:0] w_pop;
  logic [NumVn-1:0] w_full;
  logic [NumVn-1:0] w_empty;
  logic [DataW-1:0] w_rdata   [NumVn];
  logic [CntW-1:0]  w_count   [NumVn];
  logic [CntW-1:0]  w_occ_nxt [NumVn];
  logic             w_drop;

  logic [NumVn-1:0] r_avail;
  logic             r_ovf;

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [VnW-1:0]   r_lock;
  logic [VnW-1:0]   w_lock_nxt;
  logic [VnW-1:0]   r_rr;
  logic [VnW-1:0]   w_rr_nxt;
  logic [VnW-1:0]   w_grant;
  logic [VnW-1:0]   w_grant_inc;
  logic             w_valid;
  logic             w_accept;
  logic [DataW-1:0] w_head;
  logic [1:0]       w_head_type;

  assign w_wdata = {network_virtual_network_id_i,
                    network_broadcast_i,
                    network_flit_type_i,
                    network_flit_i};

  assign w_vn_ok =
    int'(network_virtual_network_id_i) < NumVn;

  // Write demux: qualify pushes; a full FIFO
  // still accepts if it pops the same cycle.
  always_comb begin
    w_push_req = '0;
    w_push     = '0;
    for (int v = 0; v < NumVn; v++) begin
      w_push_req[v] = network_valid_i &&
        (int'(network_virtual_network_id_i) == v);
      w_push[v] = w_push_req[v] &&
        (!w_full[v] || w_pop[v]);
    end
  end

  assign w_drop = network_valid_i &&
    (!w_vn_ok || |(w_push_req & w_full & ~w_pop));

  for (genvar v = 0; v < NumVn; v++) begin : g_vn
    network_ejector_vn_buffered_if #(
      .W    (DataW),
      .CntW (CntW)
    ) u_if ();

    assign u_if.push  = w_push[v];
    assign u_if.pop   = w_pop[v];
    assign u_if.wdata = w_wdata;
    assign w_rdata[v] = u_if.rdata;
    assign w_full[v]  = u_if.full;
    assign w_empty[v] = u_if.empty;
    assign w_count[v] = u_if.count;

    assign w_occ_nxt[v] = w_count[v]
                        + CntW'(w_push[v])
                        - CntW'(w_pop[v]);

    network_ejector_vn_buffered_fifo #(
      .Width (DataW),
      .Depth (FifoDepth)
    ) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .fifo   (u_if.slave)
    );
  end

  // Avail lines keep one slot in reserve for
  // the flit sent while avail is dropping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_avail <= '1;
    end else begin
      for (int v = 0; v < NumVn; v++)
        r_avail[v] <= (w_occ_nxt[v] <= AvailMax);
    end
  end

  // Sticky overflow: cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_ovf <= 1'b0;
    else if (w_drop) r_ovf <= 1'b1;
  end

  // Arbiter state, lock owner and RR pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ARB_IDLE;
      r_lock  <= '0;
      r_rr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lock  <= w_lock_nxt;
      r_rr    <= w_rr_nxt;
    end
  end

  // Next state: lock on header pop, release and
  // advance RR when the packet ends. A stalled
  // grant in IDLE pins RR so the output holds.
  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock;
    w_rr_nxt    = r_rr;
    unique case (1'b1)
      (r_state == ARB_IDLE): begin
        if (w_accept) begin
          if (w_head_type == FLIT_HEADER) begin
            w_state_nxt = ARB_LOCKED;
            w_lock_nxt  = w_grant;
          end else begin
            w_rr_nxt = w_grant_inc;
          end
        end else if (w_valid) begin
          w_rr_nxt = w_grant;
        end
      end
      (r_state == ARB_LOCKED): begin
        if (w_accept && is_pkt_end(w_head_type)) begin
          w_state_nxt = ARB_IDLE;
          w_rr_nxt    = w_grant_inc;
        end
      end
      default: ;
    endcase
  end

  // Grant select, output mux and pop strobes.
  always_comb begin
    w_grant = r_lock;
    if (r_state == ARB_IDLE)
      w_grant = VnW'(rr_pick(32'(~w_empty),
                             int'(r_rr), NumVn));
    w_grant_inc = (int'(w_grant) == NumVn - 1)
                ? '0 : w_grant + 1'b1;
    w_valid     = !w_empty[w_grant];
    w_head      = w_rdata[w_grant];
    w_head_type = w_head[TypeLsb +: FLIT_TYPE_W];
    w_accept    = w_valid && ready_i;
    w_pop       = '0;
    for (int v = 0; v < NumVn; v++)
      w_pop[v] = w_accept && (int'(w_grant) == v);
  end

  assign valid_o         = w_valid;
  assign data_o          = w_valid ? w_head : '0;
  assign network_ready_o = r_avail;
  assign overflow_o      = r_ovf;

endmodule

// File: tb/tb_network_ejector_vn_buffered.sv
// Randomized scoreboard bench for the multi-VN
// ejection port against a queue-level model.
module tb_network_ejector_vn_buffered;
  localparam int N = 3;
  localparam int D = 4;
  localparam logic [1:0] HDR = 2'b00;
  localparam logic [1:0] PAY = 2'b01;
  localparam logic [1:0] TAL = 2'b10;
  localparam logic [1:0] HT  = 2'b11;

  logic        clk;
  logic        rst_ni;
  logic        network_valid_i;
  logic [N-1:0] network_ready_o;
  logic [63:0] network_flit_i;
  logic [1:0]  network_flit_type_i;
  logic [0:0]  network_broadcast_i;
  logic [1:0]  network_virtual_network_id_i;
  logic        valid_o;
  logic        ready_i;
  logic [68:0] data_o;
  logic        overflow_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [68:0] q [N][$];
  int m_lock = -1;
  int m_hold = -1;
  int m_rr   = 0;
  bit m_ovf  = 0;
  bit open_pkt [N];

  network_ejector_vn_buffered dut (
    .clk_i                        (clk),
    .rst_ni                       (rst_ni),
    .network_valid_i              (network_valid_i),
    .network_ready_o              (network_ready_o),
    .network_flit_i               (network_flit_i),
    .network_flit_type_i          (network_flit_type_i),
    .network_broadcast_i          (network_broadcast_i),
    .network_virtual_network_id_i (network_virtual_network_id_i),
    .valid_o                      (valid_o),
    .ready_i                      (ready_i),
    .data_o                       (data_o),
    .overflow_o                   (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [68:0] act,
                     input logic [68:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic int exp_grant();
    int v;
    if (m_lock >= 0) return m_lock;
    if (m_hold >= 0) return m_hold;
    for (int i = 0; i < N; i++) begin
      v = (m_rr + i) % N;
      if (q[v].size() > 0) return v;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_avail();
    logic [N-1:0] a;
    for (int v = 0; v < N; v++)
      a[v] = (q[v].size() <= D - 2);
    return a;
  endfunction

  // Monitor: compare the presented flit with the
  // model's choice and retire it on acceptance.
  always @(negedge clk) begin : mon
    int g;
    bit ev;
    logic [68:0] hd;
    if (rst_ni === 1'b1) begin
      g  = exp_grant();
      ev = (g >= 0) && (q[g].size() > 0);
      chk("avail", 69'(network_ready_o),
          69'(exp_avail()));
      chk("overflow", 69'(overflow_o), 69'(m_ovf));
      chk("valid", 69'(valid_o), 69'(ev));
      if (ev) begin
        hd = q[g][0];
        chk("data", data_o, hd);
        if (ready_i) begin
          void'(q[g].pop_front());
          m_hold = -1;
          if (m_lock < 0) begin
            if (hd[65:64] == HDR) m_lock = g;
            else m_rr = (g + 1) % N;
          end else if (hd[65:64] == TAL ||
                       hd[65:64] == HT) begin
            m_lock = -1;
            m_rr   = (g + 1) % N;
          end
        end else begin
          m_hold = g;
        end
      end else begin
        chk("idle_data", data_o, 69'd0);
        m_hold = -1;
      end
    end
  end

  task automatic model_push(input logic [1:0] vn,
                            input logic [68:0] d);
    if (int'(vn) >= N) m_ovf = 1'b1;
    else if (q[vn].size() >= D) m_ovf = 1'b1;
    else q[vn].push_back(d);
  endtask

  // One clock of stimulus; the model learns of
  // the write at the edge that stores it.
  task automatic cyc(input bit vld,
                     input logic [1:0] vn,
                     input logic [1:0] ty,
                     input bit bc,
                     input logic [63:0] f,
                     input bit rdy);
    network_valid_i              = vld;
    network_virtual_network_id_i = vn;
    network_flit_type_i          = ty;
    network_broadcast_i          = bc;
    network_flit_i               = f;
    ready_i                      = rdy;
    @(posedge clk);
    if (vld) model_push(vn, {vn, bc, ty, f});
    #1;
    network_valid_i = 1'b0;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++)
      cyc(0, 2'd0, HDR, 0, 64'd0, rdy);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    network_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("rst_avail", 69'(network_ready_o), 69'h7);
    chk("rst_valid", 69'(valid_o), 69'd0);
    chk("rst_data", data_o, 69'd0);
    chk("rst_ovf", 69'(overflow_o), 69'd0);
    for (int v = 0; v < N; v++) begin
      q[v].delete();
      open_pkt[v] = 1'b0;
    end
    m_lock = -1;
    m_hold = -1;
    m_rr   = 0;
    m_ovf  = 1'b0;
    @(posedge clk);
    #2;
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q[0].size() + q[1].size() +
            q[2].size()) > 0 && t < 300) begin
      idle(1, 1'b1);
      t++;
    end
    n_cmp++;
    if (t >= 300) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d left expected 0",
               q[0].size() + q[1].size() + q[2].size());
    end
  endtask

  task automatic rand_phase(input int cycles);
    int vn;
    logic [1:0] ty;
    bit rdy;
    for (int i = 0; i < cycles; i++) begin
      vn  = $urandom_range(0, N - 1);
      rdy = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 7 &&
          network_ready_o[vn]) begin
        if (!open_pkt[vn]) begin
          ty = ($urandom_range(0, 1) == 0) ? HT : HDR;
          open_pkt[vn] = (ty == HDR);
        end else begin
          ty = ($urandom_range(0, 9) < 6) ? PAY : TAL;
          open_pkt[vn] = (ty == PAY);
        end
        cyc(1, 2'(vn), ty, 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, rdy);
      end else begin
        idle(1, rdy);
      end
    end
    for (int v = 0; v < N; v++) begin
      if (open_pkt[v]) begin
        for (int t = 0; t < 50 &&
             !network_ready_o[v]; t++)
          idle(1, 1'b1);
        cyc(1, 2'(v), TAL, 0, {$urandom, $urandom}, 1);
        open_pkt[v] = 1'b0;
      end
    end
  endtask

  initial begin
    rst_ni                       = 1'b0;
    network_valid_i              = 1'b0;
    network_flit_i               = '0;
    network_flit_type_i          = '0;
    network_broadcast_i          = '0;
    network_virtual_network_id_i = '0;
    ready_i                      = 1'b0;
    for (int v = 0; v < N; v++) open_pkt[v] = 1'b0;
    do_reset();

    // single header_tail, one-cycle latency
    cyc(1, 2'd1, HT, 0, 64'hA5, 1);
    idle(3, 1'b1);

    // avail drop, reserve slot, overflow
    for (int i = 0; i < 5; i++)
      cyc(1, 2'd0, HT, 0, 64'(i + 16), 0);
    idle(2, 1'b0);
    idle(6, 1'b1);
    do_reset();
    cyc(1, 2'd3, HT, 0, 64'h33, 1);
    idle(2, 1'b1);
    do_reset();

    // lock holds across an empty locked VN
    cyc(1, 2'd0, HDR, 0, 64'h100, 1);
    cyc(1, 2'd2, HT, 1, 64'h200, 1);
    idle(3, 1'b1);
    cyc(1, 2'd0, PAY, 0, 64'h101, 1);
    idle(1, 1'b1);
    cyc(1, 2'd0, TAL, 0, 64'h102, 1);
    idle(4, 1'b1);

    // round-robin fairness with wrap
    for (int r = 0; r < 2; r++)
      for (int v = 0; v < N; v++)
        cyc(1, 2'(v), HT, 0, 64'(r * 16 + v), 0);
    idle(8, 1'b1);

    // reset while locked with data queued
    cyc(1, 2'd1, HDR, 0, 64'h300, 0);
    cyc(1, 2'd1, PAY, 0, 64'h301, 0);
    cyc(1, 2'd0, HT, 0, 64'h302, 0);
    idle(1, 1'b1);
    idle(1, 1'b0);
    do_reset();
    cyc(1, 2'd0, HDR, 0, 64'h400, 1);
    cyc(1, 2'd0, TAL, 0, 64'h401, 1);
    idle(3, 1'b1);

    rand_phase(2000);
    drain();
    idle(2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
